// File: rtl/mod_mult_seq.sv
// Bit-serial multiplier: plain A*B or interleaved shift-add-reduce A*B mod N,
// scanning A MSB-first, one bit per clock, with a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for a request
// RUN    | one iteration per clock over the bits of A
// DONE   | one-cycle completion strobe, result valid
module mod_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     N,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               mode_r;
    logic [WIDTH-1:0]   a_sh, b_r, n_r;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]      cnt;

    logic               illegal;
    logic               last;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH+1:0]   t, n1, n2, r_nxt;

    assign illegal = mode && ((N == '0) || (B >= N));
    assign last    = (cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = illegal ? S_DONE : S_RUN;
                else       state_nxt = S_IDLE;
            end
            S_RUN:   if (last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Modular step: R < N keeps T = 2R + B' below 3N, so at most two
    // subtractions of N (tried as 2N first, then N) bring it back under N.
    always_comb begin
        addend  = a_sh[WIDTH-1] ? b_r : '0;
        t       = {1'b0, acc[WIDTH-1:0], 1'b0} + {2'b00, addend};
        n1      = {2'b00, n_r};
        n2      = {1'b0, n_r, 1'b0};
        r_nxt   = t;
        if (t >= n2)      r_nxt = t - n2;
        else if (t >= n1) r_nxt = t - n1;
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, addend};
        if (mode_r) acc_nxt = {{WIDTH{1'b0}}, r_nxt[WIDTH-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_r <= 1'b0;
            a_sh   <= '0;
            b_r    <= '0;
            n_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_r <= mode;
                        a_sh   <= A;
                        b_r    <= B;
                        n_r    <= N;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        if (illegal) begin
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                    acc  <= acc_nxt;
                    if (last) begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_nxt;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Self-checking bench for mod_mult_seq at WIDTH=8 and WIDTH=32: directed
// handshake/boundary cases plus random operands against an arithmetic model.
module tb_mod_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st8, md8, bz8, dn8, er8;
    logic [7:0]  a8, b8, n8;
    logic [15:0] rs8;
    logic        st32, md32, bz32, dn32, er32;
    logic [31:0] a32, b32, n32;
    logic [63:0] rs32;

    mod_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .mode(md8),
        .A(a8), .B(b8), .N(n8),
        .busy(bz8), .done(dn8), .err(er8), .result(rs8));

    mod_mult_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .mode(md32),
        .A(a32), .B(b32), .N(n32),
        .busy(bz32), .done(dn32), .err(er32), .result(rs32));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic m, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] n);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (m) begin
            if (n == 0 || b >= n) return 64'd0;
            return p % 64'(n);
        end
        return p;
    endfunction

    // Issues one request and watches until done; poke>=0 re-asserts start
    // with altered operands that many cycles into the run.
    task automatic run_op(input bit wide, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] n, input int poke,
                          output logic [63:0] res, output logic e, output int lat,
                          output int bcnt, output int ovl);
        logic bz, dn;
        @(negedge clk);
        if (wide) begin st32 = 1'b1; md32 = m; a32 = a; b32 = b; n32 = n; end
        else begin st8 = 1'b1; md8 = m; a8 = a[7:0]; b8 = b[7:0]; n8 = n[7:0]; end
        lat = -1; bcnt = 0; ovl = 0; res = 'x; e = 1'bx;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            st8 = 1'b0;
            st32 = 1'b0;
            bz = wide ? bz32 : bz8;
            dn = wide ? dn32 : dn8;
            if (bz && dn) ovl++;
            if (dn) begin
                lat = i;
                res = wide ? rs32 : 64'(rs8);
                e   = wide ? er32 : er8;
                break;
            end
            if (bz) bcnt++;
            if (i == poke) begin
                if (wide) begin st32 = 1'b1; a32 = ~a32; b32 = ~b32; end
                else begin st8 = 1'b1; a8 = ~a8; b8 = ~b8; end
            end
        end
    endtask

    task automatic do_check(input string tag, input bit wide, input logic m,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] n, input int poke,
                            input logic [63:0] exp_res);
        logic [63:0] res;
        logic        e;
        int          lat, bc, ov, w;
        bit          ill;
        run_op(wide, m, a, b, n, poke, res, e, lat, bc, ov);
        ill = m && (n == 0 || b >= n);
        w   = wide ? 32 : 8;
        chk({tag, ".result"}, res, exp_res);
        chk({tag, ".err"}, 64'(e), 64'(ill));
        chk({tag, ".latency"}, 64'(lat), ill ? 64'd0 : 64'(w));
        chk({tag, ".busy_cycles"}, 64'(bc), ill ? 64'd0 : 64'(w));
        chk({tag, ".busy_and_done"}, 64'(ov), 64'd0);
    endtask

    logic        rm;
    logic [31:0] ra, rb, rn;
    int          t_prev, n_done;

    initial begin
        st8 = 0; md8 = 0; a8 = 0; b8 = 0; n8 = 0;
        st32 = 0; md32 = 0; a32 = 0; b32 = 0; n32 = 0;
        repeat (2) @(negedge clk);
        chk("reset.busy", 64'(bz8), 64'd0);
        chk("reset.done", 64'(dn8), 64'd0);
        chk("reset.err", 64'(er8), 64'd0);
        chk("reset.result", 64'(rs8), 64'd0);
        rst_n = 1'b1;

        do_check("plain_11x02", 0, 1'b0, 32'h11, 32'h02, 32'h00, -1, 64'h0022);
        do_check("plain_FFxFF", 0, 1'b0, 32'hFF, 32'hFF, 32'h00, -1, 64'hFE01);
        do_check("mod_12x0D_17", 0, 1'b1, 32'h12, 32'h0D, 32'h17, -1, 64'h0004);
        do_check("mod_FExFD_FF", 0, 1'b1, 32'hFE, 32'hFD, 32'hFF, -1, 64'h0002);
        do_check("mod_FFxFE_FF", 0, 1'b1, 32'hFF, 32'hFE, 32'hFF, -1, 64'h0000);
        do_check("mod_illegal_n0", 0, 1'b1, 32'h35, 32'h07, 32'h00, -1, 64'h0000);
        do_check("mod_illegal_b_eq_n", 0, 1'b1, 32'h35, 32'h10, 32'h10, -1, 64'h0000);
        do_check("mod_1x1_n2", 0, 1'b1, 32'h01, 32'h01, 32'h02, -1, 64'h0001);
        do_check("start_during_run", 0, 1'b0, 32'h11, 32'h02, 32'h00, 2, 64'h0022);
        do_check("w32_plain_max", 1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, -1,
                 64'hFFFFFFFE00000001);
        do_check("w32_mod_illegal", 1, 1'b1, 32'h1234, 32'h80000000, 32'h80000000, -1, 64'h0);

        // asynchronous reset in the 3rd busy cycle, away from any clock edge
        @(negedge clk); st8 = 1'b1; md8 = 1'b0; a8 = 8'h0B; b8 = 8'h07;
        @(negedge clk); st8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.busy_before", 64'(bz8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", 64'(bz8), 64'd0);
        chk("rst_mid.done", 64'(dn8), 64'd0);
        chk("rst_mid.err", 64'(er8), 64'd0);
        chk("rst_mid.result", 64'(rs8), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        do_check("after_rst", 0, 1'b0, 32'h0B, 32'h07, 32'h00, -1, 64'd77);

        // start held high: a new operation every WIDTH+1 cycles
        @(negedge clk); st8 = 1'b1; md8 = 1'b0; a8 = 8'h05; b8 = 8'h03;
        t_prev = -1; n_done = 0;
        for (int c = 0; c < 60 && n_done < 4; c++) begin
            @(negedge clk);
            if (dn8) begin
                chk("hold.result", 64'(rs8), 64'd15);
                if (t_prev >= 0) chk("hold.period", 64'(c - t_prev), 64'd9);
                t_prev = c;
                n_done++;
            end
        end
        chk("hold.strobes", 64'(n_done), 64'd4);
        st8 = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            rm = 1'(i % 2);
            rn = 32'($urandom_range(255, 1));
            ra = 32'($urandom_range(255, 0));
            rb = rm ? 32'($urandom_range(rn - 1, 0)) : 32'($urandom_range(255, 0));
            do_check("rnd8", 0, rm, ra, rb, rn, -1, ref_mult(rm, ra, rb, rn));
        end
        for (int i = 0; i < 1000; i++) begin
            rm = 1'(i % 2);
            rn = $urandom;
            if (rn == 0) rn = 32'd1;
            ra = $urandom;
            rb = rm ? ($urandom % rn) : $urandom;
            do_check("rnd32", 1, rm, ra, rb, rn, -1, ref_mult(rm, ra, rb, rn));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_mult_seq.md
# mod_mult_seq

Parametrised sequential multiplier for the RSA datapath. It processes one operand bit per clock. It computes either the full product A*B (plain mode) or A*B mod N (modular mode, interleaved shift-add-reduce). It is the WIDTH-generic successor to the 8-bit shift-add multiplier and is the primitive the modular-exponentiation controller issues square/multiply operations to. It uses the same start/busy handshake, adds a one-cycle done strobe and an error flag, and always returns the full 2*WIDTH-bit result on one bus.

## Interface
- WIDTH, default 8: operand width in bits; legal range 2..2048.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk only in IDLE or DONE.
- mode  input  1  0 = plain product, 1 = modular product; captured with start.
- A  input  WIDTH  multiplier; captured with start.
- B  input  WIDTH  multiplicand; captured with start.
- N  input  WIDTH  modulus; captured with start; ignored when mode=0.
- busy  output  1  high while iterations run.
- done  output  1  one-cycle strobe; result valid.
- err  output  1  high with done when the modular request is illegal.
- result  output  2*WIDTH  plain: A*B; modular: {WIDTH'b0, A*B mod N}.

## Operation
- States:
  - IDLE: wait for a request.
  - RUN: iterations in progress.
  - DONE: one-cycle completion.
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, err=0, result=0, internal registers cleared. Reset during RUN aborts the operation and nothing is retained.
- Start acceptance:
  - In IDLE or DONE, start=1 at a rising edge captures mode, A, B and N into internal registers. Later input changes have no effect.
  - In RUN, start is ignored.
- Illegal modular request (mode=1 and (N==0 or B>=N)):
  - Go directly to DONE with err=1 and result=0.
  - busy is never asserted.
- Legal request:
  - Clear the accumulator and bit counter, then go to RUN.
  - Scan A MSB-first, one bit per cycle, for WIDTH cycles.
- Plain iteration:
  - P <= 2P + (a_i ? B : 0).
  - Accumulator is 2*WIDTH bits; it cannot overflow.
- Modular iteration:
  - T = 2R + (a_i ? B : 0); T < 3N.
  - R <= T - kN, with k in {0,1,2} chosen so the result is < N. The two compare/subtract steps are combinational within the same cycle.
  - Accumulator is WIDTH+2 bits.
  - Any A value is legal, including A >= N.
- After the last bit: go to DONE. result is loaded, done=1 for one cycle, and err=0. In modular mode the upper WIDTH bits of result are 0.
- DONE always returns to IDLE on the next edge unless start=1, which begins a new operation.
- result holds its value until the next accepted start. It does not change during RUN; an internal accumulator is used.

## Timing
- Let edge k be the edge at which start is accepted.
- Legal request:
  - busy=1 from edge k to edge k+WIDTH, i.e. exactly WIDTH cycles.
  - done=1 and result valid from edge k+WIDTH to k+WIDTH+1.
  - busy and done are never high together.
- Illegal request: busy stays 0; done=1 and err=1 from edge k to k+1.
- Back-to-back: start=1 while done=1 is accepted. busy rises on that same edge and no idle cycle is inserted.
- A host holding start high continuously starts a new operation every WIDTH+1 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, mode=0, A=0x11, B=0x02: after 8 busy cycles, done=1 and result=0x0022 with err=0.
- WIDTH=8, mode=0, A=0xFF, B=0xFF: result=0xFE01.
- WIDTH=8, mode=1, N=0x17, A=0x12, B=0x0D: result=0x0004.
- WIDTH=8, mode=1, N=0xFF, A=0xFE, B=0xFD: result=0x0002.
- WIDTH=8, mode=1, N=0xFF, A=0xFF, B=0xFE: result=0x0000.
- Errors and handshake:
  - mode=1 with N=0, or with N=0x10 and B=0x10: done and err are high one cycle after start, result=0, busy never rises.
  - start pulsed during RUN is ignored and the original result is unchanged.
- Reset and back-to-back:
  - rst_n pulsed low during the 3rd busy cycle: busy, done, err and result go to 0 immediately (without waiting for a clock edge). The next request after release gives the correct product.
  - start held high: consecutive done strobes are exactly 9 cycles apart (WIDTH+1).
- Randomised: 1000 random legal operands at WIDTH=8 and WIDTH=32, in both modes, checked against a reference model.
